// File: rtl/pixel_write_arbiter.sv
// Round-robin merge of per-core pixel writes onto one frame-buffer port, plus frame swap sequencing.
// Build option ARB_VSYNC_LOCK_EN: when defined, the buffer swap waits for a rising edge of vblank_in.
module pixel_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_LEN = 17,
    parameter int WIDTH    = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [NUM_REQ-1:0]           req_valid_in,
    input  logic [NUM_REQ*ADDR_LEN-1:0]  req_addr_in,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data_in,
    output logic [NUM_REQ-1:0]           req_ready_out,
    input  logic [NUM_REQ-1:0]           req_frame_done_in,
    input  logic                         vblank_in,
    output logic                         write_enable_out,
    output logic [ADDR_LEN-1:0]          write_addr_out,
    output logic [WIDTH-1:0]             write_data_out,
    output logic                         swap_buffers_out,
    output logic                         frame_start_out
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, WAIT_VBLANK, SWAP} state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   ptr_next;
    logic [PTR_W-1:0]   sel;
    logic [NUM_REQ-1:0] done_mask;
    logic [NUM_REQ-1:0] mask_next;
    logic [ADDR_LEN-1:0] gnt_addr;
    logic [WIDTH-1:0]   gnt_data;
    logic               gnt_vld;
    logic               vblank_prev;
    logic               vblank_rise;
    logic               start_pend;
    int                 idx;

    // Search starts at the pointer and wraps, so the first hit is the round-robin winner.
    always_comb begin
        req_ready_out = '0;
        gnt_vld       = 1'b0;
        gnt_idx       = '0;
        gnt_addr      = '0;
        gnt_data      = '0;
        idx           = 0;
        sel           = '0;
        if (rst_n_in && state == RUN) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                sel = idx[PTR_W-1:0];
                if (!gnt_vld && req_valid_in[sel] && !done_mask[sel]) begin
                    gnt_vld  = 1'b1;
                    gnt_idx  = sel;
                    gnt_addr = req_addr_in[sel*ADDR_LEN +: ADDR_LEN];
                    gnt_data = req_data_in[sel*WIDTH +: WIDTH];
                end
            end
        end
        if (gnt_vld) begin
            req_ready_out[gnt_idx] = 1'b1;
        end
    end

    assign ptr_next    = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign mask_next   = done_mask | req_frame_done_in;
    assign vblank_rise = vblank_in & ~vblank_prev;

    always_ff @(posedge clk_in) begin
        vblank_prev <= vblank_in;
        if (!rst_n_in) begin
            state            <= RUN;
            ptr              <= '0;
            done_mask        <= '0;
            write_enable_out <= 1'b0;
            write_addr_out   <= '0;
            write_data_out   <= '0;
            swap_buffers_out <= 1'b0;
            frame_start_out  <= 1'b0;
            start_pend       <= 1'b1;
        end else begin
            write_enable_out <= gnt_vld;
            if (gnt_vld) begin
                write_addr_out <= gnt_addr;
                write_data_out <= gnt_data;
                ptr            <= ptr_next;
            end
            // First cycle out of reset kicks the cores off with a frame start but no swap.
            start_pend       <= 1'b0;
            swap_buffers_out <= 1'b0;
            frame_start_out  <= start_pend;
            case (state)
                RUN: begin
                    done_mask <= mask_next;
                    if (&mask_next) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
`ifdef ARB_VSYNC_LOCK_EN
                    state <= WAIT_VBLANK;
`else
                    state            <= SWAP;
                    swap_buffers_out <= 1'b1;
                    frame_start_out  <= 1'b1;
`endif
                end
                WAIT_VBLANK: begin
                    if (vblank_rise) begin
                        state            <= SWAP;
                        swap_buffers_out <= 1'b1;
                        frame_start_out  <= 1'b1;
                    end
                end
                SWAP: begin
                    done_mask <= '0;
                    ptr       <= '0;
                    state     <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Randomized scoreboard bench for pixel_write_arbiter; honours ARB_VSYNC_LOCK_EN like the design.
module tb_pixel_write_arbiter;

    localparam int N  = 4;
    localparam int AL = 17;
    localparam int W  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*AL-1:0] req_addr;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_frame_done;
    logic            vblank;
    logic            write_enable;
    logic [AL-1:0]   write_addr;
    logic [W-1:0]    write_data;
    logic            swap_buffers;
    logic            frame_start;

    pixel_write_arbiter #(.NUM_REQ(N), .ADDR_LEN(AL), .WIDTH(W)) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .req_valid_in(req_valid),
        .req_addr_in(req_addr),
        .req_data_in(req_data),
        .req_ready_out(req_ready),
        .req_frame_done_in(req_frame_done),
        .vblank_in(vblank),
        .write_enable_out(write_enable),
        .write_addr_out(write_addr),
        .write_data_out(write_data),
        .swap_buffers_out(swap_buffers),
        .frame_start_out(frame_start)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [AL-1:0] a;
        logic [W-1:0]  d;
        int            c;
    } wr_t;

    wr_t wq[$];
    int  swq[$];
    int  fsq[$];

    // Reference model: frame phase 0 = arbitrating, 1 = frame complete, 2 = swap cycle.
    logic [N-1:0] m_mask = '0;
    int           m_ptr = 0;
    int           m_phase = 0;
    int           full_cyc = 0;
    logic         vb_prev = 1'b0;
    logic         pending_fs = 1'b0;
    logic         prev_rs = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N-1:0] dn, input logic vb, input logic rs);
        int n;
        int gi;
        int j;
        logic [N-1:0] eg;
        @(posedge clk);
        #1;
        n = cyc;
        if (!prev_rs) begin
            chk("rst_we", write_enable, 0);
            chk("rst_addr", write_addr, 0);
            chk("rst_data", write_data, 0);
            chk("rst_swap", swap_buffers, 0);
            chk("rst_fs", frame_start, 0);
        end
        rst_n          = rs;
        req_valid      = v;
        req_frame_done = dn;
        vblank         = vb;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AL +: AL] = AL'($urandom);
            req_data[i*W +: W]   = W'($urandom);
        end
        #1;
        eg = '0;
        gi = -1;
        if (rs && m_phase == 0) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (gi < 0 && v[j] && !m_mask[j]) gi = j;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        chk("ready", req_ready, eg);
        if (!rs) begin
            m_mask = '0;
            m_ptr = 0;
            m_phase = 0;
            pending_fs = 1'b1;
        end else begin
            if (pending_fs) begin
                fsq.push_back(n + 1);
                pending_fs = 1'b0;
            end
            if (m_phase == 0) begin
                if (gi >= 0) begin
                    wq.push_back('{req_addr[gi*AL +: AL], req_data[gi*W +: W], n + 1});
                    m_ptr = (gi + 1) % N;
                end
                m_mask = m_mask | dn;
                if (&m_mask) begin
                    m_phase = 1;
                    full_cyc = n;
                end
            end else if (m_phase == 1) begin
`ifdef ARB_VSYNC_LOCK_EN
                if (n >= full_cyc + 2 && vb && !vb_prev) begin
                    m_phase = 2;
                    swq.push_back(n + 1);
                end
`else
                if (n == full_cyc + 1) begin
                    m_phase = 2;
                    swq.push_back(n + 1);
                end
`endif
            end else begin
                m_mask = '0;
                m_ptr = 0;
                m_phase = 0;
            end
        end
        vb_prev = vb;
        prev_rs = rs;
    endtask

    // Monitor: consumes write/swap/frame-start events independently of the driver.
    logic [AL-1:0] last_a = '0;
    logic [W-1:0]  last_d = '0;
    wr_t           mon_e;
    int            exp_c;

    always @(posedge clk) begin
        if (!rst_n) begin
            last_a = '0;
            last_d = '0;
        end
    end

    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: write_enable=1 with no expected write at cycle %0d", cyc);
            end else begin
                mon_e = wq.pop_front();
                chk("write_cycle", cyc, mon_e.c);
                chk("write_addr", write_addr, mon_e.a);
                chk("write_data", write_data, mon_e.d);
                last_a = mon_e.a;
                last_d = mon_e.d;
            end
        end else begin
            chk("hold_addr", write_addr, last_a);
            chk("hold_data", write_data, last_d);
        end
        if (swap_buffers === 1'b1) begin
            checks++;
            if (swq.size() == 0) begin
                errors++;
                $display("FAIL swap_unexpected: swap_buffers=1 with none expected at cycle %0d", cyc);
            end else begin
                exp_c = swq.pop_front();
                chk("swap_cycle", cyc, exp_c);
            end
            chk("swap_frame_start", frame_start, 1);
            chk("swap_vs_write", write_enable, 0);
        end else if (frame_start === 1'b1) begin
            checks++;
            if (fsq.size() == 0) begin
                errors++;
                $display("FAIL fs_unexpected: frame_start=1 with none expected at cycle %0d", cyc);
            end else begin
                exp_c = fsq.pop_front();
                chk("fs_cycle", cyc, exp_c);
            end
        end
    end

    logic [N-1:0] rd;
    logic         vbs = 1'b0;

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        req_frame_done = '0;
        vblank = 1'b0;
        repeat (3) step('0, '0, 1'b0, 1'b0);
        // Full load, then sparse cores 1 and 3, then random valids.
        repeat (12) step(4'hF, '0, 1'b0, 1'b1);
        repeat (8) step(4'hA, '0, 1'b0, 1'b1);
        repeat (30) step(4'($urandom), '0, 1'b0, 1'b1);
        // Frame completion; core 2 is granted in the same cycle as its done pulse.
        step(4'hF, 4'h1, 1'b0, 1'b1);
        step(4'hF, 4'h2, 1'b0, 1'b1);
        step(4'h4, 4'h4, 1'b0, 1'b1);
        step(4'hF, 4'h8, 1'b1, 1'b1);
        repeat (6) step(4'hF, '0, 1'b1, 1'b1);
        repeat (4) step(4'hF, '0, 1'b0, 1'b1);
        repeat (4) step(4'hF, '0, 1'b1, 1'b1);
        repeat (3) step(4'hF, '0, 1'b0, 1'b1);
        // Long random run across several frames.
        for (int i = 0; i < 800; i++) begin
            rd = '0;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(15) == 0) rd[b] = 1'b1;
            end
            if ($urandom_range(9) == 0) vbs = ~vbs;
            step(4'($urandom), rd, vbs, 1'b1);
        end
        // Let any pending frame finish so the reset test starts from arbitration.
        for (int i = 0; i < 60; i++) begin
            if (m_phase == 0) break;
            step('0, '0, 1'(i % 2), 1'b1);
        end
        step(4'hF, 4'hF, 1'b0, 1'b1);
`ifdef ARB_VSYNC_LOCK_EN
        repeat (3) step('0, '0, 1'b0, 1'b1);
`endif
        step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step('0, '0, 1'(i % 3 == 0), 1'b1);
        repeat (10) step(4'($urandom), '0, 1'b0, 1'b1);
        repeat (3) step('0, '0, 1'b0, 1'b1);
        chk("pending_writes", wq.size(), 0);
        chk("pending_swaps", swq.size(), 0);
        chk("pending_frame_starts", fsq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_write_arbiter.md
PIXEL_WRITE_ARBITER -- requirements
Module: pixel_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of ray-marcher cores sharing the frame-buffer write port.
REQ-002 SHALL have parameter ADDR_LEN, default 17: pixel address width.
REQ-003 SHALL have parameter WIDTH, default 4: pixel color width.
REQ-004 SHALL have port clk_in, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n_in, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port req_valid_in, input, NUM_REQ: per-core pixel write request.
REQ-007 SHALL have port req_addr_in, input, NUM_REQ*ADDR_LEN: packed per-core addresses; core i in slice i.
REQ-008 SHALL have port req_data_in, input, NUM_REQ*WIDTH: packed per-core colors.
REQ-009 SHALL have port req_ready_out, output, NUM_REQ: per-core accept.
REQ-010 SHALL have port req_frame_done_in, input, NUM_REQ: per-core 1-cycle pulse; core finished its share of the frame.
REQ-011 SHALL have port vblank_in, input, 1: high during VGA vertical blanking.
REQ-012 SHALL have port write_enable_out, input-side of bram_manager write port, output, 1.
REQ-013 SHALL have port write_addr_out, output, ADDR_LEN.
REQ-014 SHALL have port write_data_out, output, WIDTH.
REQ-015 SHALL have port swap_buffers_out, output, 1: 1-cycle pulse to bram_manager.
REQ-016 SHALL have port frame_start_out, output, 1: 1-cycle pulse telling all cores to begin a new frame.

Function
REQ-017 SHALL transfer a pixel from core i in the cycle where req_valid_in[i] and req_ready_out[i] are both high.
REQ-018 SHALL assert at most one req_ready_out bit per cycle, combinationally from req_valid_in, done mask, state and round-robin pointer.
REQ-019 SHALL grant the lowest index i at or above the pointer (wrapping modulo NUM_REQ) with valid high and done bit clear.
REQ-020 SHALL set the pointer to granted index + 1 (wrap NUM_REQ-1 -> 0) after each transfer; pointer holds when no transfer.
REQ-021 SHALL register the transferred addr/data onto write_*_out with write_enable_out high exactly 1 cycle after the transfer; write_enable_out low otherwise.
REQ-022 SHALL hold write_addr_out/write_data_out at last value when write_enable_out is low.
REQ-023 SHALL keep a NUM_REQ-bit sticky done mask; req_frame_done_in[i] sets bit i; repeat pulses on a set bit are ignored.
REQ-024 SHALL accept a transfer and a done pulse from the same core in the same cycle; the pixel is written, then the core is masked.
REQ-025 SHALL implement states RUN, DRAIN, WAIT_VBLANK, SWAP.
REQ-026 RUN: arbitrate; when mask becomes all ones -> DRAIN.
REQ-027 DRAIN: no grants; wait 1 cycle for the final registered write to issue -> WAIT_VBLANK.
REQ-028 WAIT_VBLANK: no grants; on rising edge of vblank_in (low previous cycle, high this cycle) -> SWAP; vblank already high on entry does not qualify.
REQ-029 SWAP: pulse swap_buffers_out and frame_start_out for 1 cycle, clear done mask, reset pointer to 0 -> RUN.
REQ-030 SHALL never assert swap_buffers_out in the same cycle as write_enable_out.

Reset
REQ-031 SHALL, when rst_n_in low at a clock edge, set state RUN, pointer 0, done mask 0, write_enable_out 0, write_addr_out 0, write_data_out 0, swap_buffers_out 0, req_ready_out 0.
REQ-032 SHALL pulse frame_start_out for 1 cycle in the first cycle after rst_n_in returns high; swap_buffers_out stays 0.
REQ-033 SHALL discard any in-flight registered write and partial done mask on reset mid-frame; no write_enable_out issued for it.

Configuration
REQ-034 SHALL use macro ARB_VSYNC_LOCK_EN.
REQ-035 With ARB_VSYNC_LOCK_EN defined: swap gated by vblank_in edge as in REQ-028.
REQ-036 Without it: DRAIN -> SWAP directly, WAIT_VBLANK unreachable, vblank_in ignored; swap pulse 2 cycles after mask completes.

Verification
REQ-037 NUM_REQ=4, all valid every cycle, no done -> grants cycle 0,1,2,3,0,...; write_enable_out high every cycle from cycle 1, addr follows grant order.
REQ-038 Only cores 1 and 3 valid, pointer 2 -> grants 3,1,3,1; req_ready_out[0]/[2] never high.
REQ-039 Done pulses cores 0..3 at cycles 10,11,12,13 (lock enabled), vblank rises at cycle 40 -> swap_buffers_out and frame_start_out high at cycle 41 only; no grants cycles 14-41; write_enable_out low at cycle 41.
REQ-040 Same with macro undefined -> swap pulse at cycle 15, vblank ignored.
REQ-041 Core 2 asserts valid and done in same granted cycle -> that pixel written next cycle; core 2 receives no further ready until after swap.
REQ-042 rst_n_in low for 1 cycle while state WAIT_VBLANK with mask 1111 -> all outputs 0 per REQ-031, frame_start_out pulse the cycle after release, mask 0000, no swap on subsequent vblank edge.
